// File: rtl/tcam_pkg.sv
// Shared types and widths for the tcam_7x64 controller: FSM states, macro pin bundle.
package tcam_pkg;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int MATCH_W = 64;
  localparam int IDX_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_SRCH,
    ST_CAP,
    ST_RESP
  } tcam_ctrl_state_e;

  typedef struct packed {
    logic              csb;
    logic              web;
    logic [MASK_W-1:0] wmask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } tcam_pins_t;

  localparam tcam_pins_t PINS_IDLE = '{csb: 1'b1, web: 1'b1, wmask: '0, addr: '0, wdata: '0};
endpackage

// File: rtl/tcam_ctrl_if.sv
// Request/response bundle of tcam_ctrl: write, search and response handshakes.
interface tcam_ctrl_if;
  import tcam_pkg::*;

  logic               in_wr_valid;
  logic               out_wr_ready;
  logic [ADDR_W-1:0]  in_wr_addr;
  logic [DATA_W-1:0]  in_wr_data;
  logic [MASK_W-1:0]  in_wr_mask;
  logic               in_srch_valid;
  logic               out_srch_ready;
  logic [ADDR_W-1:0]  in_srch_key;
  logic               out_rsp_valid;
  logic               in_rsp_ready;
  logic [MATCH_W-1:0] out_rsp_match;
  logic               out_rsp_hit;
  logic [IDX_W-1:0]   out_rsp_idx;

  modport master (
    output in_wr_valid, in_wr_addr, in_wr_data, in_wr_mask,
    output in_srch_valid, in_srch_key, in_rsp_ready,
    input  out_wr_ready, out_srch_ready, out_rsp_valid,
    input  out_rsp_match, out_rsp_hit, out_rsp_idx
  );

  modport slave (
    input  in_wr_valid, in_wr_addr, in_wr_data, in_wr_mask,
    input  in_srch_valid, in_srch_key, in_rsp_ready,
    output out_wr_ready, out_srch_ready, out_rsp_valid,
    output out_rsp_match, out_rsp_hit, out_rsp_idx
  );
endinterface

// File: rtl/tcam_prio_enc64.sv
// Lowest-set-bit encoder for a 64-bit match vector; idx is 0 when nothing is set.
module tcam_prio_enc64
  import tcam_pkg::*;
(
  input  logic [MATCH_W-1:0] in_vec,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_hit
);
  logic [7:0]      w_grp_hit;
  logic [7:0][2:0] w_grp_idx;

  // Eight byte-wide encoders, then pick the lowest byte that has any bit set.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    logic [2:0] w_idx;
    always_comb begin
      w_idx = '0;
      for (int b = 7; b >= 0; b--) begin
        if (in_vec[gi*8 + b]) w_idx = 3'(b);
      end
    end
    assign w_grp_idx[gi] = w_idx;
    assign w_grp_hit[gi] = |in_vec[gi*8 +: 8];
  end

  always_comb begin
    out_idx = '0;
    for (int g = 7; g >= 0; g--) begin
      if (w_grp_hit[g]) out_idx = {3'(g), w_grp_idx[g]};
    end
  end

  assign out_hit = |w_grp_hit;
endmodule

// File: rtl/tcam_ctrl.sv
// Controller for one tcam_7x64 macro: round-robin write/search arbitration, one op in flight.
// Optional statistics counters are built when TCAM_CTRL_STATS_EN is defined.
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               in_clk,
  input  logic               in_rst,
  tcam_ctrl_if.slave         bus,
  output logic               out_tcam_csb,
  output logic               out_tcam_web,
  output logic [MASK_W-1:0]  out_tcam_wmask,
  output logic [ADDR_W-1:0]  out_tcam_addr,
  output logic [DATA_W-1:0]  out_tcam_wdata,
  input  logic [MATCH_W-1:0] in_tcam_rdata
`ifdef TCAM_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]   out_srch_cnt,
  output logic [CNT_W-1:0]   out_hit_cnt
`endif
);
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("tcam_ctrl: CNT_W must be at least 1");
  end

  tcam_ctrl_state_e   r_state, w_state_next;
  tcam_pins_t         r_pins, w_pins_next;
  logic               r_ptr;
  logic [MATCH_W-1:0] r_match;
  logic               w_grant_wr, w_grant_srch, w_accept;

  // r_ptr low: search wins a tie; a lone requester is always granted.
  assign w_grant_srch = bus.in_srch_valid & (~bus.in_wr_valid | ~r_ptr);
  assign w_grant_wr   = bus.in_wr_valid & (~bus.in_srch_valid | r_ptr);
  assign w_accept     = bus.out_wr_ready | bus.out_srch_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= ST_IDLE;
      r_pins  <= PINS_IDLE;
      r_ptr   <= 1'b0;
      r_match <= '0;
    end else begin
      r_state <= w_state_next;
      r_pins  <= w_pins_next;
      if (w_accept) r_ptr <= ~r_ptr;
      if (r_state == ST_CAP) r_match <= in_tcam_rdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_wr)        w_state_next = ST_WR;
        else if (w_grant_srch) w_state_next = ST_SRCH;
      end
      ST_WR:   w_state_next = ST_IDLE;
      ST_SRCH: w_state_next = ST_CAP;
      ST_CAP:  w_state_next = ST_RESP;
      ST_RESP: if (bus.in_rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Macro pins are registered from the accept cycle so they are live in WR/SRCH only.
  always_comb begin
    bus.out_wr_ready   = 1'b0;
    bus.out_srch_ready = 1'b0;
    w_pins_next        = PINS_IDLE;
    if (r_state == ST_IDLE) begin
      bus.out_wr_ready   = w_grant_wr;
      bus.out_srch_ready = w_grant_srch;
      if (w_grant_wr) begin
        w_pins_next = '{csb: 1'b0, web: 1'b0, wmask: bus.in_wr_mask,
                        addr: bus.in_wr_addr, wdata: bus.in_wr_data};
      end else if (w_grant_srch) begin
        w_pins_next = '{csb: 1'b0, web: 1'b1, wmask: '0,
                        addr: bus.in_srch_key, wdata: '0};
      end
    end
  end

  assign bus.out_rsp_valid = (r_state == ST_RESP);
  assign bus.out_rsp_match = r_match;

  tcam_prio_enc64 u_enc (
    .in_vec  (r_match),
    .out_idx (bus.out_rsp_idx),
    .out_hit (bus.out_rsp_hit)
  );

  assign out_tcam_csb   = r_pins.csb;
  assign out_tcam_web   = r_pins.web;
  assign out_tcam_wmask = r_pins.wmask;
  assign out_tcam_addr  = r_pins.addr;
  assign out_tcam_wdata = r_pins.wdata;

`ifdef TCAM_CTRL_STATS_EN
  logic [CNT_W-1:0] r_srch_cnt, r_hit_cnt;
  logic             w_rsp_fire;

  assign w_rsp_fire = (r_state == ST_RESP) & bus.in_rsp_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_srch_cnt <= '0;
      r_hit_cnt  <= '0;
    end else if (w_rsp_fire) begin
      r_srch_cnt <= r_srch_cnt + CNT_W'(1);
      if (bus.out_rsp_hit) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign out_srch_cnt = r_srch_cnt;
  assign out_hit_cnt  = r_hit_cnt;
`endif
endmodule

// File: tb/tb_tcam_ctrl.sv
// Self-checking bench for tcam_ctrl: directed scenarios plus random ops against a lookup-table model.
module tb_tcam_ctrl;
  import tcam_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcam_ctrl_if bus();

  logic        csb, web;
  logic [3:0]  wmask;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [63:0] rdata;
`ifdef TCAM_CTRL_STATS_EN
  logic [31:0] srch_cnt, hit_cnt;
`endif

  tcam_ctrl #(.CNT_W(32)) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .bus            (bus),
    .out_tcam_csb   (csb),
    .out_tcam_web   (web),
    .out_tcam_wmask (wmask),
    .out_tcam_addr  (addr),
    .out_tcam_wdata (wdata),
    .in_tcam_rdata  (rdata)
`ifdef TCAM_CTRL_STATS_EN
    ,
    .out_srch_cnt   (srch_cnt),
    .out_hit_cnt    (hit_cnt)
`endif
  );

  // Macro model: one-cycle registered search result, garbage on the bus otherwise.
  logic [63:0] tbl [128];
  always @(posedge clk) begin
    if (!csb && web) rdata <= tbl[addr];
    else             rdata <= {$urandom, $urandom};
  end

  int n_tests = 0;
  int n_fail = 0;
  int n_accept = 0;
  int exp_srch_cnt = 0;
  int exp_hit_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_idx(input logic [63:0] m);
    for (int i = 0; i < 64; i++) begin
      if (m[i]) return 64'(i);
    end
    return 64'd0;
  endfunction

  task automatic chk_pins_idle(input string tag);
    chk(tag, {csb, web, wmask, addr, wdata}, {1'b1, 1'b1, 4'h0, 7'h00, 32'h0});
  endtask

  task automatic chk_stats();
`ifdef TCAM_CTRL_STATS_EN
    chk("srch_cnt", srch_cnt, 64'(exp_srch_cnt));
    chk("hit_cnt", hit_cnt, 64'(exp_hit_cnt));
`endif
  endtask

  // One arbitrated operation: request, check grant, follow it through to IDLE.
  task automatic op(input bit wv, input bit sv, input logic [6:0] waddr, input logic [31:0] wd,
                    input logic [3:0] wm, input logic [6:0] key, input int hold, output bit got_srch);
    bit          exp_srch;
    int          t;
    logic [63:0] m;
    got_srch = 1'b0;
    bus.in_wr_valid   = wv;
    bus.in_wr_addr    = waddr;
    bus.in_wr_data    = wd;
    bus.in_wr_mask    = wm;
    bus.in_srch_valid = sv;
    bus.in_srch_key   = key;
    bus.in_rsp_ready  = 1'b0;
    exp_srch = sv && (!wv || (n_accept % 2 == 0));
    #1;
    t = 0;
    while (!(bus.out_wr_ready || bus.out_srch_ready) && t < 20) begin
      tick();
      #1;
      t++;
    end
    chk("grant_wait", 64'(t < 20), 64'd1);
    if (t >= 20) begin
      bus.in_wr_valid = 1'b0;
      bus.in_srch_valid = 1'b0;
      return;
    end
    got_srch = bus.out_srch_ready;
    chk("grant_srch", 64'(got_srch), 64'(exp_srch));
    chk("ready_onehot", 64'(bus.out_wr_ready & bus.out_srch_ready), 64'd0);
    n_accept++;
    tick(); #1;
    chk("busy_ready", {bus.out_wr_ready, bus.out_srch_ready}, 64'd0);
    if (!got_srch) begin
      chk("wr_pins", {csb, web, wmask, addr, wdata}, {1'b0, 1'b0, wm, waddr, wd});
      tick(); #1;
      chk("wr_done_ready", 64'(bus.out_wr_ready | bus.out_srch_ready), 64'd1);
      chk_pins_idle("wr_done_pins");
      $display("[TB] write addr=0x%02h data=0x%08h mask=0x%h", waddr, wd, wm);
    end else begin
      chk("srch_pins", {csb, web, wmask, addr, wdata}, {1'b0, 1'b1, 4'h0, key, 32'h0});
      m = tbl[key];
      tick(); #1;
      chk("cap_rsp_valid", 64'(bus.out_rsp_valid), 64'd0);
      chk("cap_ready", {bus.out_wr_ready, bus.out_srch_ready}, 64'd0);
      chk_pins_idle("cap_pins");
      tick(); #1;
      chk("rsp_valid", 64'(bus.out_rsp_valid), 64'd1);
      chk("rsp_match", bus.out_rsp_match, m);
      chk("rsp_hit", 64'(bus.out_rsp_hit), 64'(m != 0));
      chk("rsp_idx", 64'(bus.out_rsp_idx), ref_idx(m));
      for (int h = 0; h < hold; h++) begin
        tick(); #1;
        chk("hold_valid", 64'(bus.out_rsp_valid), 64'd1);
        chk("hold_match", bus.out_rsp_match, m);
        chk("hold_hit_idx", {bus.out_rsp_hit, bus.out_rsp_idx}, {(m != 0), ref_idx(m)[5:0]});
        chk("hold_ready", {bus.out_wr_ready, bus.out_srch_ready}, 64'd0);
      end
      bus.in_rsp_ready = 1'b1;
      exp_srch_cnt++;
      if (m != 0) exp_hit_cnt++;
      tick(); #1;
      bus.in_rsp_ready = 1'b0;
      chk("rsp_done_valid", 64'(bus.out_rsp_valid), 64'd0);
      chk("rsp_done_ready", 64'(bus.out_wr_ready | bus.out_srch_ready), 64'd1);
      chk_stats();
      $display("[TB] search key=0x%02h match=0x%016h hit=%0d idx=%0d hold=%0d",
               key, m, (m != 0), ref_idx(m), hold);
    end
    bus.in_wr_valid   = 1'b0;
    bus.in_srch_valid = 1'b0;
  endtask

  initial begin
    bit       g;
    bit [3:0] order;
    int       t;
    bit       wv, sv;

    for (int i = 0; i < 128; i++) begin
      tbl[i] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(3) == 0) tbl[i] = '0;
    end
    tbl[7'h12] = 64'h0000_0100_0000_0010;
    tbl[7'h7F] = 64'h0;

    bus.in_wr_valid = 1'b0; bus.in_wr_addr = '0; bus.in_wr_data = '0; bus.in_wr_mask = '0;
    bus.in_srch_valid = 1'b0; bus.in_srch_key = '0; bus.in_rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_rsp_valid", 64'(bus.out_rsp_valid), 64'd0);
    chk("reset_rsp", {bus.out_rsp_hit, bus.out_rsp_idx}, 64'd0);
    chk("reset_match", bus.out_rsp_match, 64'd0);
    chk_pins_idle("reset_pins");
    chk_stats();
    rst = 1'b0;
    tick();

    // Contention from reset: search first, then alternate.
    for (int k = 0; k < 4; k++) begin
      op(1'b1, 1'b1, 7'($urandom), $urandom, 4'($urandom), 7'($urandom), 0, g);
      order[k] = g;
    end
    chk("contention_order", 64'(order), 64'(4'b0101));

    op(1'b1, 1'b0, 7'h05, 32'hDEADBEEF, 4'hF, 7'h00, 0, g);
    chk("write_only_grant", 64'(g), 64'd0);
    op(1'b0, 1'b1, 7'h00, 32'h0, 4'h0, 7'h12, 0, g);
    chk("search_only_grant", 64'(g), 64'd1);
    op(1'b1, 1'b1, 7'h11, 32'h1234_5678, 4'h3, 7'h12, 5, g);
    chk("backpressure_grant", 64'(g), 64'd1);
    op(1'b0, 1'b1, 7'h00, 32'h0, 4'h0, 7'h7F, 0, g);

    for (int k = 0; k < 30; k++) begin
      wv = 1'($urandom_range(1));
      sv = 1'($urandom_range(1));
      if (!wv && !sv) sv = 1'b1;
      op(wv, sv, 7'($urandom), $urandom, 4'($urandom), 7'($urandom), $urandom_range(3), g);
    end

    // Abort a search in CAP with reset; nothing may come out of it.
    bus.in_srch_valid = 1'b1;
    bus.in_srch_key = 7'h12;
    #1;
    t = 0;
    while (!bus.out_srch_ready && t < 20) begin
      tick(); #1; t++;
    end
    chk("abort_grant_wait", 64'(t < 20), 64'd1);
    tick(); #1;
    bus.in_srch_valid = 1'b0;
    tick(); #1;
    chk("abort_cap_valid", 64'(bus.out_rsp_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_accept = 0;
    exp_srch_cnt = 0;
    exp_hit_cnt = 0;
    chk("abort_rsp_valid", 64'(bus.out_rsp_valid), 64'd0);
    chk("abort_match", bus.out_rsp_match, 64'd0);
    chk_pins_idle("abort_pins");
    chk_stats();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_quiet", {bus.out_rsp_valid, csb}, 64'b01);
    end
    $display("[TB] reset during CAP, search aborted");

    op(1'b1, 1'b1, 7'h01, 32'hCAFE_F00D, 4'h1, 7'h12, 0, g);
    chk("post_reset_ptr", 64'(g), 64'd1);
    op(1'b0, 1'b1, 7'h00, 32'h0, 4'h0, 7'h7F, 1, g);
    op(1'b0, 1'b1, 7'h00, 32'h0, 4'h0, 7'h12, 0, g);
`ifdef TCAM_CTRL_STATS_EN
    chk("final_srch_cnt", srch_cnt, 64'd3);
    chk("final_hit_cnt", hit_cnt, 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tcam_ctrl.md
TCAM_CTRL -- requirements
Module: tcam_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, the width of the statistics counters.
REQ-002 The block SHALL have port in_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port in_rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have the following write-request ports:
- in_wr_valid, input, 1, write request.
- out_wr_ready, output, 1, write accepted.
- in_wr_addr, input, 7, row address.
- in_wr_data, input, 32, row data.
- in_wr_mask, input, 4, byte mask.
REQ-005 The block SHALL have the following search-request ports:
- in_srch_valid, input, 1, search request.
- out_srch_ready, output, 1, search accepted.
- in_srch_key, input, 7, search key.
REQ-006 The block SHALL have the following response ports:
- out_rsp_valid, output, 1, result valid.
- in_rsp_ready, input, 1, result consumed.
- out_rsp_match, output, 64, raw match vector.
- out_rsp_hit, output, 1, any bit of the match vector set.
- out_rsp_idx, output, 6, lowest set match index.
REQ-007 The block SHALL have the following macro-side ports, which connect one tcam_7x64 instance:
- out_tcam_csb, output, 1, active-low select.
- out_tcam_web, output, 1, active-low write enable.
- out_tcam_wmask, output, 4, byte mask.
- out_tcam_addr, output, 7, address.
- out_tcam_wdata, output, 32, write data.
- in_tcam_rdata, input, 64, match vector.
REQ-008 The block SHALL have out_srch_cnt (output, CNT_W) and out_hit_cnt (output, CNT_W), present only under TCAM_CTRL_STATS_EN.

Function
REQ-009 FSM states SHALL be IDLE, WR, SRCH, CAP and RESP; only one operation is in flight at a time.
REQ-010 Readiness and arbitration in IDLE:
- out_wr_ready and out_srch_ready SHALL be high only in IDLE, and only for the granted requester.
- Both ready signals SHALL be low in every other state.
REQ-011 Arbitration when both requests are valid SHALL be round-robin via a 1-bit pointer, which toggles on every accepted request; a lone valid requester is always granted.
REQ-012 On write accept in cycle T: the FSM SHALL go IDLE→WR.
- In T+1 the macro pins are registered as csb=0, web=0, addr=in_wr_addr, wdata=in_wr_data, wmask=in_wr_mask.
- In T+2 the FSM returns to IDLE.
REQ-013 On search accept in cycle T: the FSM SHALL go IDLE→SRCH.
- In T+1 the macro pins are csb=0, web=1, addr=in_srch_key.
- In T+2 (CAP), in_tcam_rdata is captured.
- In T+3 (RESP), out_rsp_valid=1.
REQ-014 Response holding: in RESP, out_rsp_match/hit/idx and out_rsp_valid SHALL hold stable until in_rsp_ready=1, then the FSM returns to IDLE on the next cycle.
REQ-015 Index encoding: out_rsp_idx SHALL be the index of the least-significant set bit of the match vector; when the vector is zero, out_rsp_hit=0 and out_rsp_idx=0.
REQ-016 Outside WR/SRCH the macro pins SHALL idle at csb=1, web=1, addr=0, wmask=0, wdata=0.
REQ-017 Requests arriving while the FSM is not in IDLE SHALL be stalled (ready low), never dropped or queued.

Reset
REQ-018 When in_rst=1 at a clock edge, the block SHALL take the following reset values regardless of state, including mid-search or in RESP:
- state goes to IDLE and the pointer selects search.
- out_rsp_valid, out_rsp_match, out_rsp_hit and out_rsp_idx are 0.
- macro pins are at their idle values.
- counters are 0.
REQ-019 An operation interrupted by reset SHALL produce no response; a write already presented to the macro in WR is not retracted.

Configuration
REQ-020 With TCAM_CTRL_STATS_EN defined:
- out_srch_cnt SHALL increment on every search response handshake.
- out_hit_cnt SHALL increment on every such handshake with hit=1.
- Both counters wrap modulo 2^CNT_W.
REQ-021 Without TCAM_CTRL_STATS_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 The shared package tcam_pkg SHALL hold:
- the state enum tcam_ctrl_state_e.
- address/data/mask/match width constants (7/32/4/64).
- the index width (6).
REQ-023 The lowest-set-bit encoder SHALL be a combinational sub-module, tcam_prio_enc64 (64-bit in; 6-bit idx and hit out).

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Write only: addr=0x05, data=0xDEADBEEF, mask=0xF. Required: macro sees csb=0, web=0, addr=0x05 in the cycle after accept, and ready is low for exactly 1 cycle.
- Search only: the model returns 0x0000_0100_0000_0010 for key 0x12. Required: rsp_valid 3 cycles after accept, hit=1, idx=4.
- Miss: the model returns 0 for key 0x7F. Required: hit=0, idx=0, match=0.
- Contention: wr_valid and srch_valid held high for 4 accepts from reset. Required: grant order is search, write, search, write.
- Backpressure: rsp_ready held low for 5 cycles. Required: the response stays stable, both readies stay low, and the FSM reaches IDLE 1 cycle after rsp_ready rises.
- Reset in CAP, plus stats: assert in_rst in CAP, then run 3 searches with 2 hits. Required: no response for the aborted search and no macro select after reset; under TCAM_CTRL_STATS_EN, srch_cnt=3 and hit_cnt=2.
